// File: rtl/breath_led_mc_pkg.sv
// Shared encodings for the multi-channel breathing-LED engine.
package breath_led_mc_pkg;

  typedef enum logic [1:0] {
    MODE_BREATH    = 2'b00,
    MODE_ON        = 2'b01,
    MODE_OFF       = 2'b10,
    MODE_FADE_HOLD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RISE = 2'b01,
    ST_FALL = 2'b10,
    ST_HOLD = 2'b11
  } state_e;

  // Counter width that stays legal when the modulus is 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/breath_timebase.sv
// Shared free-running timebase: PWM tick divider, PWM period counter and
// duty-step divider, all clock-enable based on the single system clock.
module breath_timebase
  import breath_led_mc_pkg::*;
#(
  parameter int TICK_DIV         = 50,
  parameter int PWM_STEPS        = 1000,
  parameter int STEP_PWM_PERIODS = 1,
  parameter int DW               = $clog2(PWM_STEPS + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  output logic [DW-1:0] pwm_cnt_o,
  output logic          pwm_wrap_o,
  output logic          duty_step_o
);

  localparam int DIV_W  = cnt_width(TICK_DIV);
  localparam int STEP_W = cnt_width(STEP_PWM_PERIODS);

  logic [DIV_W-1:0]  div_q,  div_d;
  logic [DW-1:0]     pwm_q,  pwm_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              tick_s;

  // Terminal-count decode and next counter values.
  always_comb begin
    tick_s      = (div_q == DIV_W'(TICK_DIV - 1));
    pwm_wrap_o  = tick_s && (pwm_q == DW'(PWM_STEPS - 1));
    duty_step_o = pwm_wrap_o && (step_q == STEP_W'(STEP_PWM_PERIODS - 1));
    if (tick_s) div_d = '0;
    else        div_d = div_q + DIV_W'(1);
    if (pwm_wrap_o)  pwm_d = '0;
    else if (tick_s) pwm_d = pwm_q + DW'(1);
    else             pwm_d = pwm_q;
    if (duty_step_o)     step_d = '0;
    else if (pwm_wrap_o) step_d = step_q + STEP_W'(1);
    else                 step_d = step_q;
  end

  // Counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q  <= '0;
      pwm_q  <= '0;
      step_q <= '0;
    end else begin
      div_q  <= div_d;
      pwm_q  <= pwm_d;
      step_q <= step_d;
    end
  end

  assign pwm_cnt_o = pwm_q;

endmodule

// File: rtl/breath_led_mc.sv
// Multi-channel breathing-LED PWM engine: per-channel ramp FSM and PWM
// compare, all channels sharing one timebase.
module breath_led_mc
  import breath_led_mc_pkg::*;
#(
  parameter int   CH_NUM           = 4,
  parameter int   TICK_DIV         = 50,
  parameter int   PWM_STEPS        = 1000,
  parameter int   STEP_PWM_PERIODS = 1,
  parameter logic LED_ACTIVE       = 1'b0,
  localparam int  DW               = $clog2(PWM_STEPS + 1)
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [CH_NUM-1:0]    en,
  input  logic [2*CH_NUM-1:0]  mode,
  input  logic [CH_NUM*DW-1:0] phase,
  output logic [CH_NUM-1:0]    led,
  output logic [CH_NUM-1:0]    cycle_done
);

  logic [DW-1:0] pwm_cnt_s;
  logic          duty_step_s;

  breath_timebase #(
    .TICK_DIV        (TICK_DIV),
    .PWM_STEPS       (PWM_STEPS),
    .STEP_PWM_PERIODS(STEP_PWM_PERIODS),
    .DW              (DW)
  ) u_timebase (
    .clk_i      (sys_clk),
    .rst_ni     (sys_rst_n),
    .pwm_cnt_o  (pwm_cnt_s),
    .pwm_wrap_o (),
    .duty_step_o(duty_step_s)
  );

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    state_e        state_q, state_d;
    logic [DW-1:0] duty_q, duty_d;
    logic          led_q, led_d;
    logic          done_q, done_d;
    logic          en_s, kill_s;
    mode_e         mode_s;
    logic [DW-1:0] phase_s, duty_inc_s, duty_dec_s;

    assign en_s       = en[g];
    assign mode_s     = mode_e'(mode[2*g +: 2]);
    assign phase_s    = phase[DW*g +: DW];
    // Disable and forced modes win over any duty step in the same cycle.
    assign kill_s     = !en_s || (mode_s == MODE_ON) || (mode_s == MODE_OFF);
    assign duty_inc_s = duty_q + DW'(1);
    assign duty_dec_s = duty_q - DW'(1);

    // State, duty and registered outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        state_q <= ST_IDLE;
        duty_q  <= '0;
        led_q   <= ~LED_ACTIVE;
        done_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        duty_q  <= duty_d;
        led_q   <= led_d;
        done_q  <= done_d;
      end
    end

    // Next-state and duty ramp.
    always_comb begin
      state_d = state_q;
      duty_d  = duty_q;
      done_d  = 1'b0;
      if (kill_s) begin
        state_d = ST_IDLE;
        duty_d  = '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (phase_s >= DW'(PWM_STEPS)) begin
              duty_d  = DW'(PWM_STEPS);
              state_d = (mode_s == MODE_BREATH) ? ST_FALL : ST_HOLD;
            end else begin
              duty_d  = phase_s;
              state_d = ST_RISE;
            end
          end
          ST_RISE: begin
            if (duty_step_s) begin
              duty_d = duty_inc_s;
              if (duty_inc_s == DW'(PWM_STEPS)) begin
                state_d = (mode_s == MODE_BREATH) ? ST_FALL : ST_HOLD;
              end else begin
                state_d = ST_RISE;
              end
            end else begin
              state_d = ST_RISE;
            end
          end
          ST_FALL, ST_HOLD: begin
            // HOLD only leaves the top once breathing is requested again.
            if (duty_step_s && ((state_q == ST_FALL) || (mode_s == MODE_BREATH))) begin
              duty_d = duty_dec_s;
              if (duty_dec_s == '0) begin
                state_d = ST_RISE;
                done_d  = 1'b1;
              end else if (mode_s == MODE_FADE_HOLD) begin
                state_d = ST_RISE;
              end else begin
                state_d = ST_FALL;
              end
            end else begin
              state_d = state_q;
            end
          end
          default: begin
            state_d = ST_IDLE;
            duty_d  = '0;
          end
        endcase
      end
    end

    // LED level: forced modes bypass the PWM compare.
    always_comb begin
      if (!en_s) begin
        led_d = ~LED_ACTIVE;
      end else begin
        case (mode_s)
          MODE_ON:  led_d = LED_ACTIVE;
          MODE_OFF: led_d = ~LED_ACTIVE;
          default:  led_d = (pwm_cnt_s < duty_q) ? LED_ACTIVE : ~LED_ACTIVE;
        endcase
      end
    end

    assign led[g]        = led_q;
    assign cycle_done[g] = done_q;
  end

endmodule

// File: tb/tb_breath_led_mc.sv
// Self-checking bench for breath_led_mc: directed scenarios plus random
// mode/enable/phase changes against a cycle-count based reference model.
module tb_breath_led_mc;

  localparam int CH   = 2;
  localparam int TDIV = 2;
  localparam int STEPS = 4;
  localparam int SPP  = 1;
  localparam int DW   = 3;
  localparam bit ACT  = 1'b0;
  localparam int STEP_PERIOD = TDIV * STEPS * SPP;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n;
  logic [CH-1:0]     en;
  logic [2*CH-1:0]   mode;
  logic [CH*DW-1:0]  phase;
  logic [CH-1:0]     led;
  logic [CH-1:0]     cycle_done;

  int vec  = 0;
  int errs = 0;
  int k;
  int m_duty [CH];
  int m_dir  [CH];
  bit m_act  [CH];
  logic [CH-1:0] exp_led, exp_cd;

  breath_led_mc #(
    .CH_NUM(CH), .TICK_DIV(TDIV), .PWM_STEPS(STEPS),
    .STEP_PWM_PERIODS(SPP), .LED_ACTIVE(ACT)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en), .mode(mode),
    .phase(phase), .led(led), .cycle_done(cycle_done)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [CH-1:0] got, input logic [CH-1:0] exp);
    vec++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%b expected=%b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chki(input string tag, input int got, input int exp);
    vec++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    k = 0;
    for (int i = 0; i < CH; i++) begin
      m_duty[i] = 0; m_dir[i] = 0; m_act[i] = 1'b0;
    end
  endtask

  // Reference: the timebase is pure arithmetic on the edge count since reset;
  // each channel is an integer duty with a direction (+1 up, -1 down, 0 parked at top).
  task automatic model_edge();
    int pc, md, ph;
    bit stp;
    pc  = (k / TDIV) % STEPS;
    stp = ((k % STEP_PERIOD) == STEP_PERIOD - 1);
    for (int i = 0; i < CH; i++) begin
      md = int'(mode[2*i +: 2]);
      ph = int'(phase[DW*i +: DW]);
      exp_cd[i] = 1'b0;
      if (!en[i] || md == 1 || md == 2) begin
        exp_led[i] = (en[i] && md == 1) ? ACT : !ACT;
        m_act[i] = 1'b0; m_duty[i] = 0; m_dir[i] = 0;
      end else begin
        exp_led[i] = (pc < m_duty[i]) ? ACT : !ACT;
        if (!m_act[i]) begin
          m_act[i]  = 1'b1;
          m_duty[i] = (ph < STEPS) ? ph : STEPS;
          if (ph >= STEPS) m_dir[i] = (md == 0) ? -1 : 0;
          else             m_dir[i] = 1;
        end else if (stp) begin
          if (m_dir[i] == 0 && md == 0) m_dir[i] = -1;
          m_duty[i] += m_dir[i];
          if (m_duty[i] == STEPS) m_dir[i] = (md == 0) ? -1 : 0;
          else if (m_duty[i] == 0 && m_dir[i] == -1) begin
            m_dir[i] = 1; exp_cd[i] = 1'b1;
          end else if (m_dir[i] == -1 && md == 3) m_dir[i] = 1;
        end
      end
    end
    k++;
  endtask

  task automatic cycle();
    @(posedge sys_clk);
    model_edge();
    #1;
    chk("led", led, exp_led);
    chk("cycle_done", cycle_done, exp_cd);
  endtask

  initial begin
    int lows, dones;
    bit found;
    sys_rst_n = 1'b1; en = 2'b11; mode = 4'b0000; phase = '0;
    #1 sys_rst_n = 1'b0;
    #1;
    chk("reset_led", led, 2'b11);
    chk("reset_cycle_done", cycle_done, 2'b00);
    repeat (2) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    model_reset();
    repeat (6) cycle();
    chki("post_reset_led_idle", int'(led), 3);

    // Breath on ch0 from phase 0.
    en = 2'b00; cycle();
    en = 2'b01; mode = 4'b0000; phase = '0;
    repeat (80) cycle();
    lows = 0; dones = 0;
    for (int n = 0; n < 8 * STEP_PERIOD; n++) begin
      cycle();
      if (led[0] == ACT) lows++;
      if (cycle_done[0]) dones++;
    end
    chki("breath_low_clocks", lows, 32);
    chki("breath_done_pulses", dones, 1);

    // Phase offset: ch1 starts at the top and falls.
    en = 2'b00; cycle();
    en = 2'b11; mode = 4'b0000; phase = {3'd4, 3'd0};
    repeat (100) cycle();

    // Fade-in-hold from phase 2, then release into breath.
    en = 2'b00; cycle();
    en = 2'b01; mode = 4'b0011; phase = {3'd0, 3'd2};
    repeat (40) cycle();
    mode = 4'b0000;
    repeat (20) cycle();

    // Force / disable mid-ramp at duty 3 while rising.
    en = 2'b00; cycle();
    en = 2'b01; mode = 4'b0000; phase = '0;
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      if (m_act[0] && m_dir[0] == 1 && m_duty[0] == 3) found = 1'b1;
      else cycle();
    end
    chki("reach_rise_duty3", int'(found), 1);
    mode = 4'b0001; cycle();
    chki("force_on_led0", int'(led[0]), 0);
    mode = 4'b0010; cycle();
    chki("force_off_led0", int'(led[0]), 1);
    en = 2'b00; mode = 4'b0000; repeat (3) cycle();
    en = 2'b01; phase = {3'd0, 3'd1};
    repeat (30) cycle();

    // Disable in the same cycle FALL reaches 0: no cycle_done.
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      if (m_act[0] && m_dir[0] == -1 && m_duty[0] == 1 && (k % STEP_PERIOD) == STEP_PERIOD - 1)
        found = 1'b1;
      else cycle();
    end
    chki("reach_fall_duty1", int'(found), 1);
    en = 2'b00; cycle();
    chki("suppressed_done", int'(cycle_done[0]), 0);
    chki("disabled_led0", int'(led[0]), 1);

    // Asynchronous reset in the middle of operation.
    en = 2'b11; mode = 4'b0000; phase = {3'd4, 3'd2};
    repeat (37) cycle();
    #2 sys_rst_n = 1'b0;
    #1;
    chk("midreset_led", led, 2'b11);
    chk("midreset_cycle_done", cycle_done, 2'b00);
    repeat (2) begin
      @(posedge sys_clk); #1;
      chk("held_reset_led", led, 2'b11);
    end
    sys_rst_n = 1'b1;
    model_reset();
    repeat (20) cycle();

    // Random enable/mode/phase changes.
    for (int n = 0; n < 900; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        en    = CH'($urandom_range(0, 3));
        mode  = (2*CH)'($urandom);
        phase = (CH*DW)'($urandom);
        if ($urandom_range(0, 1) == 1) mode = 4'b0000;
        if ($urandom_range(0, 2) == 0) en = 2'b11;
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
